// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with a pending-write scoreboard.
// Holds the default geometry, the default counter type and the index of the
// hardwired zero register. Imported by the interface, the scoreboard and
// the top level.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_CNT_W  = 2;

  // Pending-write counter at the default width.
  typedef logic [DEF_CNT_W-1:0] cnt_t;

  // Register that reads as zero when the zero-register option is on.
  localparam int ZERO_IDX = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between the decode/write-back logic and the register file.
// Carries:
//   wr_en/wr_addr/wr_data   write-back port
//   rsv_en/rsv_addr         reservation of a destination register
//   rd_addr1/rd_addr2       read indices
//   rd_data1/rd_data2       combinational read data
//   busy1/busy2/hazard      pending-write status of the read registers
//   ovf_err                 sticky reservation-overflow flag
// master: the pipeline driving the register file; slave: the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              busy1;
  logic              busy2;
  logic              hazard;
  logic              ovf_err;

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, busy1, busy2, hazard, ovf_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, busy1, busy2, hazard, ovf_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters.
// A reservation increments the counter of rsv_addr, a write-back decrements
// the counter of wr_addr (never below zero). A reservation that finds its
// counter saturated is dropped and raises the sticky ovf_err.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   rsv_en, rsv_addr     reservation strobe and index
//   wr_en, wr_addr       write-back strobe and index
//   rd_addr1, rd_addr2   indices whose busy status is reported
//   busy1, busy2         combinational busy status of the read indices
//   ovf_err              sticky overflow flag
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              busy1,
  output logic              busy2,
  output logic              ovf_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic             ovf_err_q;
  logic             ovf_err_d;

  always_comb begin
    logic zero_slot;
    logic rsv_sel;
    logic wr_sel;
    ovf_err_d = ovf_err_q;
    zero_slot = 1'b0;
    rsv_sel   = 1'b0;
    wr_sel    = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      zero_slot = (ZERO_REG != 0) && (a == ZERO_IDX);
      rsv_sel   = rsv_en && (rsv_addr == ADDR_W'(a)) && !zero_slot;
      wr_sel    = wr_en && (wr_addr == ADDR_W'(a));
      cnt_d[a]  = cnt_q[a];
      if (rsv_sel && (cnt_q[a] == CNT_MAX)) begin
        // Reservation is lost; a write-back in the same cycle still retires
        // one of the outstanding operations.
        ovf_err_d = 1'b1;
        if (wr_sel) cnt_d[a] = cnt_q[a] - 1'b1;
      end else if (rsv_sel && wr_sel) begin
        // New reservation replaces the retiring one: net count unchanged,
        // including the case of a plain write to an idle register.
        cnt_d[a] = cnt_q[a];
      end else if (rsv_sel) begin
        cnt_d[a] = cnt_q[a] + 1'b1;
      end else if (wr_sel && (cnt_q[a] != '0)) begin
        cnt_d[a] = cnt_q[a] - 1'b1;
      end
      if (zero_slot) cnt_d[a] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) cnt_q[a] <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  // A write-back retiring the last pending operation clears busy in the
  // same cycle when bypassing; reservations only show up after the edge.
  function automatic logic busy_of(input logic [CNT_W-1:0] cnt,
                                   input logic [ADDR_W-1:0] ra);
    logic rel;
    rel = (BYPASS != 0) && wr_en && (wr_addr == ra) && (cnt != '0);
    return (cnt - CNT_W'(rel)) != '0;
  endfunction

  assign busy1   = busy_of(cnt_q[rd_addr1], rd_addr1);
  assign busy2   = busy_of(cnt_q[rd_addr2], rd_addr2);
  assign ovf_err = ovf_err_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, optional hardwired
// zero register and a pending-write scoreboard for hazard detection.
// Ports:
//   clk     clock, all state updates on the rising edge
//   reset   asynchronous active-high reset: registers, counters, ovf_err
//   bus     regfile_sb_if slave: write-back, reservation, two read ports,
//           busy/hazard status and the sticky overflow flag
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_IDX));
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && !is_zero(bus.wr_addr)) regs_d[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) regs_q[a] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Zero register wins over the bypass so a dropped write never leaks out.
  function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] ra,
                                               input logic [DATA_W-1:0] stored,
                                               input logic              we,
                                               input logic [ADDR_W-1:0] wa,
                                               input logic [DATA_W-1:0] wd);
    if (is_zero(ra)) return '0;
    if ((BYPASS != 0) && we && (wa == ra)) return wd;
    return stored;
  endfunction

  assign bus.rd_data1 = rd_mux(bus.rd_addr1, regs_q[bus.rd_addr1],
                               bus.wr_en, bus.wr_addr, bus.wr_data);
  assign bus.rd_data2 = rd_mux(bus.rd_addr2, regs_q[bus.rd_addr2],
                               bus.wr_en, bus.wr_addr, bus.wr_data);

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rd_addr1 (bus.rd_addr1),
    .rd_addr2 (bus.rd_addr2),
    .busy1    (bus.busy1),
    .busy2    (bus.busy2),
    .ovf_err  (bus.ovf_err)
  );

  assign bus.hazard = bus.busy1 | bus.busy2;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances share one stimulus stream, one with
// zero register and bypass on (defaults), one with both off. A behavioural
// model keeps plain arrays of register values and pending counts and is
// checked against both instances on every falling edge; directed literal
// checks pin the model on the scenarios of interest.
module tb_regfile_sb;

  localparam int CMAX = 3;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;

  int n_vec;
  int n_err;
  bit chk_en;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();

  assign bus0.wr_en = wr_en;   assign bus1.wr_en = wr_en;
  assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;
  assign bus0.rsv_en = rsv_en; assign bus1.rsv_en = rsv_en;
  assign bus0.rsv_addr = rsv_addr; assign bus1.rsv_addr = rsv_addr;
  assign bus0.rd_addr1 = rd_addr1; assign bus1.rd_addr1 = rd_addr1;
  assign bus0.rd_addr2 = rd_addr2; assign bus1.rd_addr2 = rd_addr2;

  regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1), .CNT_W(2))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0), .CNT_W(2))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] mreg [2][16];
  int          mcnt [2][16];
  bit          movf [2];

  function automatic bit cfg_zr(input int c); return (c == 0); endfunction
  function automatic bit cfg_bp(input int c); return (c == 0); endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        mreg[c][a] = '0;
        mcnt[c][a] = 0;
      end
      movf[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input int c);
    bit rsv_ok;
    bit same;
    rsv_ok = rsv_en && !(cfg_zr(c) && rsv_addr == 4'd0);
    if (rsv_ok && mcnt[c][rsv_addr] == CMAX) begin
      movf[c] = 1'b1;
      rsv_ok  = 1'b0;
    end
    same = wr_en && rsv_ok && (wr_addr == rsv_addr);
    if (!same) begin
      if (rsv_ok) mcnt[c][rsv_addr] = mcnt[c][rsv_addr] + 1;
      if (wr_en && mcnt[c][wr_addr] > 0) mcnt[c][wr_addr] = mcnt[c][wr_addr] - 1;
    end
    if (wr_en && !(cfg_zr(c) && wr_addr == 4'd0)) mreg[c][wr_addr] = wr_data;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else for (int c = 0; c < 2; c++) model_edge(c);
  end

  function automatic logic [31:0] exp_rd(input int c, input logic [3:0] a);
    if (cfg_zr(c) && a == 4'd0) return '0;
    if (cfg_bp(c) && wr_en && wr_addr == a) return wr_data;
    return mreg[c][a];
  endfunction

  function automatic logic exp_busy(input int c, input logic [3:0] a);
    int p;
    p = mcnt[c][a];
    if (cfg_bp(c) && wr_en && wr_addr == a && p > 0) p = p - 1;
    return p != 0;
  endfunction

  // ---------------- checking ----------------
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%08h required=%08h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%b required=%b", nm, act, req);
    end
  endtask

  logic [31:0] o_rd1 [2];
  logic [31:0] o_rd2 [2];
  logic        o_b1  [2];
  logic        o_b2  [2];
  logic        o_hz  [2];
  logic        o_ovf [2];
  assign o_rd1[0] = bus0.rd_data1; assign o_rd1[1] = bus1.rd_data1;
  assign o_rd2[0] = bus0.rd_data2; assign o_rd2[1] = bus1.rd_data2;
  assign o_b1[0]  = bus0.busy1;    assign o_b1[1]  = bus1.busy1;
  assign o_b2[0]  = bus0.busy2;    assign o_b2[1]  = bus1.busy2;
  assign o_hz[0]  = bus0.hazard;   assign o_hz[1]  = bus1.hazard;
  assign o_ovf[0] = bus0.ovf_err;  assign o_ovf[1] = bus1.ovf_err;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        logic eb1;
        logic eb2;
        eb1 = exp_busy(c, rd_addr1);
        eb2 = exp_busy(c, rd_addr2);
        chk32($sformatf("m%0d_rd1@%0d", c, rd_addr1), o_rd1[c], exp_rd(c, rd_addr1));
        chk32($sformatf("m%0d_rd2@%0d", c, rd_addr2), o_rd2[c], exp_rd(c, rd_addr2));
        chk1($sformatf("m%0d_busy1@%0d", c, rd_addr1), o_b1[c], eb1);
        chk1($sformatf("m%0d_busy2@%0d", c, rd_addr2), o_b2[c], eb2);
        chk1($sformatf("m%0d_hazard", c), o_hz[c], eb1 | eb2);
        chk1($sformatf("m%0d_ovf", c), o_ovf[c], movf[c]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; chk_en = 1'b0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
    model_clear();
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state across all addresses
    for (int a = 0; a < 16; a++) begin
      step();
      rd_addr1 = 4'(a); rd_addr2 = 4'(15 - a);
      #1;
      chk32("rst_rd1", bus0.rd_data1, 32'h0);
      chk32("rst_rd2_nz", bus1.rd_data2, 32'h0);
      chk1("rst_busy1", bus0.busy1, 1'b0);
      chk1("rst_ovf", bus0.ovf_err, 1'b0);
    end

    // Plain write, read next cycle
    step(); wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    step(); wr_en = 1'b0; rd_addr1 = 4'd5;
    #1;
    chk32("wr5_byp", bus0.rd_data1, 32'hDEADBEEF);
    chk32("wr5_nobyp", bus1.rd_data1, 32'hDEADBEEF);

    // Bypass versus no bypass
    step(); wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h1234; rd_addr1 = 4'd3;
    #1;
    chk32("byp_same_cycle", bus0.rd_data1, 32'h1234);
    chk32("nobyp_same_cycle", bus1.rd_data1, 32'h0);
    step(); wr_en = 1'b0;
    #1;
    chk32("nobyp_next_cycle", bus1.rd_data1, 32'h1234);

    // Zero register
    step(); wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 4'd0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    #1;
    chk32("zero_rd_same", bus0.rd_data1, 32'h0);
    step(); wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk32("zero_rd_next", bus0.rd_data1, 32'h0);
    chk1("zero_busy", bus0.busy1, 1'b0);
    chk1("zero_ovf", bus0.ovf_err, 1'b0);
    chk32("nozero_rd", bus1.rd_data2, 32'hFFFF_FFFF);

    // Scoreboard: two reservations, then three writes
    step(); rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr2 = 4'd7;
    #1;
    chk1("rsv_same_cycle", bus0.busy2, 1'b0);
    step();
    #1;
    chk1("rsv_one_cycle_later", bus0.busy2, 1'b1);
    step(); rsv_en = 1'b0;
    #1;
    chk1("sb_busy2", bus0.busy2, 1'b1);
    chk1("sb_hazard", bus0.hazard, 1'b1);
    step(); wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77;
    #1;
    chk1("sb_first_write", bus0.busy2, 1'b1);
    chk1("sb_first_write_nobyp", bus1.busy2, 1'b1);
    step(); wr_data = 32'h78;
    #1;
    chk1("sb_second_write", bus0.busy2, 1'b0);
    chk1("sb_second_hazard", bus0.hazard, 1'b0);
    chk1("sb_second_write_nobyp", bus1.busy2, 1'b1);
    step(); wr_data = 32'h79;
    #1;
    chk1("sb_third_write", bus0.busy2, 1'b0);
    step(); wr_en = 1'b0;
    #1;
    chk1("sb_idle", bus0.busy2, 1'b0);
    chk1("sb_idle_nobyp", bus1.busy2, 1'b0);
    chk32("sb_data", bus0.rd_data2, 32'h79);

    // Overflow on register 9
    for (int i = 0; i < 4; i++) begin
      step(); rsv_en = 1'b1; rsv_addr = 4'd9;
      if (i == 3) begin
        #1;
        chk1("ovf_before_4th", bus0.ovf_err, 1'b0);
      end
    end
    step(); rsv_en = 1'b0; rd_addr1 = 4'd9;
    #1;
    chk1("ovf_set", bus0.ovf_err, 1'b1);
    chk1("ovf_set_nz", bus1.ovf_err, 1'b1);
    chk1("ovf_busy", bus0.busy1, 1'b1);
    step(); rsv_en = 1'b1; rsv_addr = 4'd9; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h99;
    step(); rsv_en = 1'b0;
    #1;
    chk1("ovf_cnt2_first_release", bus0.busy1, 1'b1);
    step();
    #1;
    chk1("ovf_cnt2_second_release", bus0.busy1, 1'b0);
    chk1("ovf_sticky", bus0.ovf_err, 1'b1);
    step(); wr_en = 1'b0;

    // Asynchronous reset between edges
    step(); wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'hA5;
    step(); wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 4'd4;
    step();
    step(); rsv_en = 1'b0; rd_addr1 = 4'd4;
    #1;
    chk1("arst_pre_busy", bus0.busy1, 1'b1);
    chk32("arst_pre_data", bus0.rd_data1, 32'hA5);
    #1 reset = 1'b1;
    #1;
    chk1("arst_busy", bus0.busy1, 1'b0);
    chk32("arst_data", bus0.rd_data1, 32'h0);
    chk32("arst_data_nz", bus1.rd_data1, 32'h0);
    chk1("arst_hazard", bus0.hazard, 1'b0);
    chk1("arst_ovf", bus0.ovf_err, 1'b0);
    step(); step(); reset = 1'b0;

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
      end else begin
        reset    = 1'b0;
        wr_en    = 1'($urandom_range(0, 1));
        rsv_en   = ($urandom_range(0, 2) == 0);
        wr_data  = $urandom;
        wr_addr  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        rsv_addr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      rd_addr1 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rd_addr2 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    end
    step(); reset = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    step();
    @(posedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with write-to-read bypass, optional hardwired zero register, and a per-register pending-write scoreboard. It replaces the fixed 16x32 register set in the processor datapath. Decode uses the scoreboard to detect read-after-write hazards against multi-cycle operations (loads, multiplies) that have reserved a destination but not yet written it back.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1: register 0 reads as 0, ignores writes and reservations
- BYPASS, 1, 1: same-cycle write data and write-release are visible on read ports
- CNT_W, 2, width of per-register pending counter; max pending = 2**CNT_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back register index
- wr_data  in  DATA_W  write-back data
- rsv_en  in  1  reserve strobe: a pending write is issued to rsv_addr
- rsv_addr  in  ADDR_W  reserved register index
- rd_addr1, rd_addr2  in  ADDR_W  read indices
- rd_data1, rd_data2  out  DATA_W  read data (combinational)
- busy1, busy2  out  1  read register has outstanding pending writes
- hazard  out  1  busy1 | busy2
- ovf_err  out  1  sticky: reservation dropped at counter max

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W x CNT_W pending counters.
- Write: when wr_en is high, registers[wr_addr] <= wr_data at the edge. Writes to address 0 are dropped when ZERO_REG=1.
- Read: rd_dataN = registers[rd_addrN]. When ZERO_REG=1 and rd_addrN==0, the output is 0.
  - BYPASS=1: if wr_en and wr_addr==rd_addrN (and the address is not a zeroed reg 0), rd_dataN = wr_data.
- Pending counter cnt[a], updated at the edge:
  - reserve only: +1
  - write only: -1
  - reserve and write to the same address in the same cycle: unchanged
  - reserve and write to different addresses: each updates independently
- Write to a register with cnt==0 is a plain write; cnt stays 0 (no underflow).
- Reserve with cnt==max is dropped; ovf_err sets and holds until reset. A simultaneous write to the same address still decrements.
- ZERO_REG=1: cnt[0] is held at 0; reservations of reg 0 are ignored and do not set ovf_err.
- Busy:
  - BYPASS=0: busyN = (cnt[rd_addrN] != 0).
  - BYPASS=1: busyN = (cnt[rd_addrN] - (wr_en && wr_addr==rd_addrN && cnt!=0)) != 0. A releasing write is visible in the same cycle.
  - Reservations never affect busy in their own cycle.
- hazard = busy1 | busy2.

## Timing
- Reset (asynchronous, any time): all registers 0, all cnt 0, ovf_err 0. Outputs are therefore rd_data 0, busy 0, hazard 0 while reset is asserted.
- Reset mid-operation discards all pending reservations. No write is performed in a cycle where reset is high at the edge.
- Read latency is 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency:
  - BYPASS=1: data is visible on reads in the same cycle.
  - BYPASS=0: data is visible the cycle after the edge.
- Reserve-to-busy latency: 1 cycle.
- No handshake: all strobes are single-cycle and accepted unconditionally, except the overflow case.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W/CNT_W localparams, a cnt_t typedef, and a ZERO_IDX constant.
- Sub-module regfile_scoreboard:
  - owns the counter array, the busy computation, and ovf_err
  - inputs: rsv_*, wr_en/wr_addr, and the rd_addrs
  - regfile_sb instantiates it alongside the data array and bypass muxes.

## Test plan
- Reset then read all addresses -> every rd_data=0, busy=0, ovf_err=0. Write reg 5 = 0xDEADBEEF, read next cycle -> 0xDEADBEEF.
- Bypass (BYPASS=1): wr_en, wr_addr=3, wr_data=0x1234, rd_addr1=3 in the same cycle -> rd_data1=0x1234 that cycle. With BYPASS=0 -> old value that cycle, 0x1234 the next.
- Zero reg: write 0xFFFF_FFFF to reg 0, reserve reg 0 -> rd_data=0, busy=0, ovf_err=0.
- Scoreboard: reserve reg 7 twice (cnt=2), rd_addr2=7 -> busy2=1, hazard=1. First write -> busy2 still 1. Second write -> busy2=0 in the same cycle (BYPASS=1). A third write -> cnt stays 0.
- Overflow: reserve reg 9 four times with CNT_W=2 -> cnt=3 and ovf_err=1 after the 4th. Reserve+write reg 9 in the same cycle -> cnt=2.
- Asynchronous reset asserted mid-clock with cnt[4]=2 and reg 4=0xA5 -> busy and data clear immediately, without waiting for a clock edge.
